// File: rtl/digit_serial_sub.sv
// Digit-serial subtractor: diff = a - b, one 2-bit digit per clock, LSB digit first,
// with the inter-digit borrow held in a register behind a start/busy/done handshake.
module digit_serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned N  = WIDTH / 2;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_n;
  logic             br_q;
  logic [CW-1:0]    cnt;
  logic [1:0]       a_dig, b_dig;
  logic [2:0]       dig;
  logic             last;

  // Digit select and write-back are decoded per digit so no bits go unused.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt == CW'(i)) begin
        a_dig = a_q[2*i +: 2];
        b_dig = b_q[2*i +: 2];
      end
    end
    dig   = {1'b0, a_dig} - {1'b0, b_dig} - {2'b00, br_q};
    res_n = res_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt == CW'(i)) res_n[2*i +: 2] = dig[1:0];
    end
    last = (cnt == CW'(N - 1));
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (start) state_n = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      br_q   <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            res_q <= '0;
            br_q  <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          res_q <= res_n;
          br_q  <= dig[2];
          // Outputs update only when the final digit lands, so partial results never show.
          if (last) begin
            diff   <= res_n;
            borrow <= dig[2];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_sub.sv
// Directed bench for digit_serial_sub at WIDTH 8, plus 2- and 16-bit instances
// checked against a - b over edge and random vectors.
module tb_digit_serial_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        start8, busy8, done8, borrow8;
  logic [7:0]  a8, b8, diff8;
  logic        start2, busy2, done2, borrow2;
  logic [1:0]  a2, b2, diff2;
  logic        start16, busy16, done16, borrow16;
  logic [15:0] a16, b16, diff16;

  int tests = 0;
  int fails = 0;

  digit_serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );
  digit_serial_sub #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .borrow(borrow2)
  );
  digit_serial_sub #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow(borrow16)
  );

  // Launches one 8-bit op and observes samples 0..9 (sample s = negedge after edge E_s).
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib,
                      output int done_cnt, output int done_at, output int busy_cnt,
                      output logic [7:0] rd, output logic rb, output logic [7:0] pre_diff);
    @(negedge clk);
    a8 = ia; b8 = ib; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    done_cnt = 0; done_at = -1; busy_cnt = 0; rd = '0; rb = 1'b0; pre_diff = '0;
    for (int s = 0; s < 10; s++) begin
      if (s > 0) @(negedge clk);
      if (s == 3) pre_diff = diff8;
      if (busy8) busy_cnt++;
      if (done8) begin
        done_cnt++;
        done_at = s;
        rd = diff8;
        rb = borrow8;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start8 = 0; start2 = 0; start16 = 0;
    a8 = '0; b8 = '0; a2 = '0; b2 = '0; a16 = '0; b16 = '0;
    #12;
    tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy8); end
    tests++; if (done8 !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done8); end
    tests++; if (diff8 !== 8'h00) begin fails++; $display("FAIL reset_diff: got %h expected 00", diff8); end
    tests++; if (borrow8 !== 1'b0) begin fails++; $display("FAIL reset_borrow: got %b expected 0", borrow8); end
    tests++; if (busy16 !== 1'b0 || diff16 !== 16'h0) begin
      fails++; $display("FAIL reset_w16: got busy=%b diff=%h expected 0/0000", busy16, diff16);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int dc, da, bc;
    logic [7:0] rd, pd;
    logic rb;
    run8(8'h5A, 8'h3C, dc, da, bc, rd, rb, pd);
    tests++; if (dc !== 1) begin fails++; $display("FAIL basic_done_count: got %0d expected 1", dc); end
    tests++; if (da !== 4) begin fails++; $display("FAIL basic_latency: got %0d expected 4", da); end
    tests++; if (bc !== 5) begin fails++; $display("FAIL basic_busy_cycles: got %0d expected 5", bc); end
    tests++; if (rd !== 8'h1E) begin fails++; $display("FAIL basic_diff: got %h expected 1e", rd); end
    tests++; if (rb !== 1'b0) begin fails++; $display("FAIL basic_borrow: got %b expected 0", rb); end
    tests++; if (pd !== 8'h00) begin fails++; $display("FAIL basic_no_partial: got %h expected 00", pd); end
  endtask

  task automatic test_ripple;
    int dc, da, bc;
    logic [7:0] rd, pd;
    logic rb;
    run8(8'h00, 8'h01, dc, da, bc, rd, rb, pd);
    tests++; if (rd !== 8'hFF || rb !== 1'b1) begin
      fails++; $display("FAIL ripple_00_01: got %h/%b expected ff/1", rd, rb);
    end
    tests++; if (pd !== 8'h1E) begin fails++; $display("FAIL ripple_hold_prev: got %h expected 1e", pd); end
    run8(8'h80, 8'h01, dc, da, bc, rd, rb, pd);
    tests++; if (rd !== 8'h7F || rb !== 1'b0 || da !== 4) begin
      fails++; $display("FAIL ripple_80_01: got %h/%b at %0d expected 7f/0 at 4", rd, rb, da);
    end
  endtask

  task automatic test_extremes;
    int dc, da, bc;
    logic [7:0] rd, pd;
    logic rb;
    run8(8'hFF, 8'hFF, dc, da, bc, rd, rb, pd);
    tests++; if (rd !== 8'h00 || rb !== 1'b0) begin
      fails++; $display("FAIL equal_ff: got %h/%b expected 00/0", rd, rb);
    end
    run8(8'h00, 8'hFF, dc, da, bc, rd, rb, pd);
    tests++; if (rd !== 8'h01 || rb !== 1'b1) begin
      fails++; $display("FAIL zero_minus_ff: got %h/%b expected 01/1", rd, rb);
    end
  endtask

  task automatic test_start_busy;
    int dc;
    logic [7:0] rd;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    dc = 0; rd = '0;
    for (int s = 0; s < 12; s++) begin
      if (s > 0) @(negedge clk);
      if (done8) begin dc++; rd = diff8; end
      if (s == 1) begin start8 = 1'b1; a8 = 8'h99; b8 = 8'h11; end
      if (s == 2) start8 = 1'b0;
      if (s == 4) start8 = 1'b1;
      if (s == 5) start8 = 1'b0;
    end
    tests++; if (dc !== 1) begin fails++; $display("FAIL busy_single_done: got %0d expected 1", dc); end
    tests++; if (rd !== 8'h0F) begin fails++; $display("FAIL busy_ignore_inputs: got %h expected 0f", rd); end
  endtask

  task automatic test_reset_mid;
    int dc, da, bc;
    logic [7:0] rd, pd;
    logic rb;
    @(negedge clk);
    a8 = 8'h34; b8 = 8'h12; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    tests++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      fails++; $display("FAIL midreset_ctrl: got busy=%b done=%b expected 0/0", busy8, done8);
    end
    tests++; if (diff8 !== 8'h00 || borrow8 !== 1'b0) begin
      fails++; $display("FAIL midreset_outputs: got %h/%b expected 00/0", diff8, borrow8);
    end
    @(negedge clk);
    reset = 1'b0;
    dc = 0;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      if (done8 || busy8) dc++;
    end
    tests++; if (dc !== 0) begin fails++; $display("FAIL midreset_no_done: got %0d active cycles expected 0", dc); end
    run8(8'h34, 8'h12, dc, da, bc, rd, rb, pd);
    tests++; if (rd !== 8'h22 || rb !== 1'b0 || dc !== 1) begin
      fails++; $display("FAIL midreset_fresh: got %h/%b x%0d expected 22/0 x1", rd, rb, dc);
    end
  endtask

  // Accepts land on edges after negedges 0,6,12,18; each done shows 5 negedges later.
  task automatic test_held_start;
    logic [7:0] va, vb;
    logic [8:0] exp_q[$];
    logic [8:0] e;
    int seen;
    seen = 0;
    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      if (done8) seen++;
      if (t % 6 == 5) begin
        e = exp_q.pop_front();
        tests++; if (done8 !== 1'b1 || diff8 !== e[7:0] || borrow8 !== e[8]) begin
          fails++;
          $display("FAIL held_op_t%0d: got done=%b %h/%b expected 1 %h/%b", t, done8, diff8, borrow8, e[7:0], e[8]);
        end
      end
      va = 8'(t * 37 + 5);
      vb = 8'(t * 11 + 90);
      a8 = va; b8 = vb; start8 = 1'b1;
      if (t % 6 == 0) exp_q.push_back({va < vb, 8'(va - vb)});
    end
    start8 = 1'b0;
    tests++; if (seen !== 4) begin fails++; $display("FAIL held_done_count: got %0d expected 4", seen); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_sweep;
    logic [1:0]  va2, vb2, gd2;
    logic [15:0] va16, vb16, gd16;
    logic        gb;
    int lat;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin va2 = 2'd0; vb2 = 2'd3; end
      else if (i == 1) begin va2 = 2'd3; vb2 = 2'd3; end
      else begin va2 = 2'($urandom); vb2 = 2'($urandom); end
      @(negedge clk);
      a2 = va2; b2 = vb2; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      lat = -1; gd2 = '0; gb = 1'b0;
      for (int s = 0; s < 6; s++) begin
        if (s > 0) @(negedge clk);
        if (done2 && lat < 0) begin lat = s; gd2 = diff2; gb = borrow2; end
      end
      tests++; if (lat !== 1 || gd2 !== 2'(va2 - vb2) || gb !== (va2 < vb2)) begin
        fails++;
        $display("FAIL w2_%0d: got %h/%b at %0d expected %h/%b at 1", i, gd2, gb, lat, 2'(va2 - vb2), va2 < vb2);
      end
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin va16 = 16'h0000; vb16 = 16'h0001; end
      else if (i == 1) begin va16 = 16'hFFFF; vb16 = 16'h0000; end
      else begin va16 = 16'($urandom); vb16 = 16'($urandom); end
      @(negedge clk);
      a16 = va16; b16 = vb16; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      lat = -1; gd16 = '0; gb = 1'b0;
      for (int s = 0; s < 12; s++) begin
        if (s > 0) @(negedge clk);
        if (done16 && lat < 0) begin lat = s; gd16 = diff16; gb = borrow16; end
      end
      tests++; if (lat !== 8 || gd16 !== 16'(va16 - vb16) || gb !== (va16 < vb16)) begin
        fails++;
        $display("FAIL w16_%0d: got %h/%b at %0d expected %h/%b at 8", i, gd16, gb, lat, 16'(va16 - vb16), va16 < vb16);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_extremes();
    test_start_busy();
    test_reset_mid();
    test_held_start();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
